divider_speed_ctrl: RTL
=======================

Name: divider_speed_ctrl

Overview:
Run-time controller for the variable-rate clock divider. It accepts speed commands through a valid/ready handshake and ramps the divider's speed input toward the target in bounded steps. Every speed change is paired with a one-cycle divider counter reset, so the divider never runs past a shrunken terminal count. The block sits between the user-input/command logic and the divider, in the 50 MHz clk domain.

Parameters:
SPEED_W, 26, width of speed values and cmd_data
MIN_SPEED, 1, lowest legal speed; output never goes below it, so the divider never divides by 0
MAX_SPEED, 1000000, highest legal speed
INIT_SPEED, 1, speed and target after reset; must lie within [MIN_SPEED, MAX_SPEED]
RAMP_STEP, 1000, maximum change of speed per ramp step
RAMP_PERIOD, 500000, clk cycles spent in RAMP before each step; must be ≥1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  0=SET, 1=INC, 2=DEC, 3=JUMP
cmd_data  input  SPEED_W  operand
speed  output  SPEED_W  registered speed value driven to the divider
div_rst_n  output  1  active-low divider counter reset
speed_update  output  1  one-cycle pulse, coincident with div_rst_n=0
busy  output  1  state is not IDLE
at_target  output  1  state is IDLE and speed equals the target

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high and on the edge that releases it:
  - speed = target = INIT_SPEED, state = IDLE, ramp timer = 0
  - div_rst_n = 0, speed_update = 0, cmd_ready = 0
- In the first cycle after reset: div_rst_n = 1, cmd_ready = 1, at_target = 1.
- A command is accepted on a clk edge where cmd_valid && cmd_ready. cmd_ready = 1 in IDLE and RAMP and 0 in SYNC. The requester holds cmd_valid, cmd_op and cmd_data stable until the command is accepted.
- Target update on acceptance. Arithmetic uses SPEED_W+1 bits, and every result is clamped to [MIN_SPEED, MAX_SPEED]:
  - SET: target = clamp(cmd_data)
  - INC: target = clamp(target + cmd_data), saturating at MAX_SPEED
  - DEC: target = clamp(target - cmd_data); underflow gives MIN_SPEED
  - JUMP: speed = target = clamp(cmd_data) on the same edge; next state is SYNC, ramp timer = 0
- States:
  - IDLE: on an accepted SET/INC/DEC whose new target differs from speed, go to RAMP with timer = 0. If the new target equals speed, stay in IDLE with no pulse.
  - RAMP: the timer increments every cycle. When timer == RAMP_PERIOD-1:
    - speed moves toward target by min(RAMP_STEP, |target-speed|)
    - timer clears and the state goes to SYNC, all on the same edge
    - If a command accepted on that same edge makes target == the current speed, go to IDLE instead, with no step.
  - Command accepted in RAMP: the target is updated and the timer is not restarted. If target == speed afterwards, go to IDLE on that edge.
  - SYNC: lasts exactly one cycle, with div_rst_n = 0, speed_update = 1, and speed already holding the new value. Next state is RAMP if speed != target, otherwise IDLE.
- Step cadence during a ramp: one speed change every RAMP_PERIOD+1 cycles. The first step comes RAMP_PERIOD cycles after the accepting edge.
- speed changes only on edges that enter SYNC, and each change produces exactly one SYNC cycle.
- busy = (state != IDLE). at_target = (state == IDLE).
- Asserting reset mid-ramp or during SYNC aborts the ramp and restores the reset values. No partial step is applied.

Test Plan:
Bench parameters: MIN_SPEED=1, MAX_SPEED=100, INIT_SPEED=50, RAMP_STEP=10, RAMP_PERIOD=4.
1. Reset released → speed=50, div_rst_n=0 through the release edge then 1, at_target=1, busy=0, cmd_ready=1.
2. SET 75 accepted at edge t → speed=60 at t+4, 70 at t+9, 75 at t+14. Each step gives one cycle of speed_update=1/div_rst_n=0. at_target=1 from t+15.
3. INC 200 from 50 → target 100, ramp ends at speed 100. DEC 1000 → target 1, ramp ends at speed 1 and never reads 0.
4. JUMP 0 from 50 → speed=1 on the accepting edge, a single SYNC pulse, then IDLE with at_target=1. JUMP 500 → speed=100.
5. cmd_valid held high with SET 20 during a SYNC cycle → cmd_ready=0 in that cycle. The command is accepted the next cycle, and the ramp reverses direction toward 20 without restarting the timer.
6. reset pulsed while in RAMP at speed 70 toward 90 → speed=50, state IDLE, no further speed_update. SET 50 afterwards → no pulse, busy stays 0.

Source files
------------

// File: rtl/divider_speed_ctrl.sv
// Run-time speed controller for the variable-rate clock divider: accepts SET/INC/DEC/JUMP
// commands and ramps the divider speed toward the target in bounded, paced steps.
module divider_speed_ctrl #(
    parameter int unsigned SPEED_W     = 26,
    parameter int unsigned MIN_SPEED   = 1,
    parameter int unsigned MAX_SPEED   = 1000000,
    parameter int unsigned INIT_SPEED  = 1,
    parameter int unsigned RAMP_STEP   = 1000,
    parameter int unsigned RAMP_PERIOD = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [SPEED_W-1:0] cmd_data,
    output logic [SPEED_W-1:0] speed,
    output logic               div_rst_n,
    output logic               speed_update,
    output logic               busy,
    output logic               at_target
);

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_SYNC} state_e;

    localparam int unsigned        TIMER_W    = $clog2(RAMP_PERIOD + 1);
    localparam logic [SPEED_W:0]   MIN_X      = (SPEED_W + 1)'(MIN_SPEED);
    localparam logic [SPEED_W:0]   MAX_X      = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] INIT_V     = SPEED_W'(INIT_SPEED);
    localparam logic [SPEED_W-1:0] STEP_V     = SPEED_W'(RAMP_STEP);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RAMP_PERIOD - 1);

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] target_q, target_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               rst_hold_q;

    logic               accept;
    logic               jump;
    logic               going_up;
    logic [SPEED_W-1:0] new_target;
    logic [SPEED_W-1:0] delta;
    logic [SPEED_W-1:0] step;
    logic [SPEED_W-1:0] stepped;

    function automatic logic [SPEED_W-1:0] clamp(input logic [SPEED_W:0] v);
        logic [SPEED_W:0] r;
        r = v;
        if (v < MIN_X) r = MIN_X;
        else if (v > MAX_X) r = MAX_X;
        return r[SPEED_W-1:0];
    endfunction

    // rst_hold_q keeps the divider in reset and commands blocked until the cycle after release.
    assign cmd_ready    = !rst_hold_q && (state_q != ST_SYNC);
    assign div_rst_n    = !rst_hold_q && (state_q != ST_SYNC);
    assign speed_update = !rst_hold_q && (state_q == ST_SYNC);
    assign busy         = (state_q != ST_IDLE);
    assign at_target    = (state_q == ST_IDLE);
    assign speed        = speed_q;
    assign accept       = cmd_valid && cmd_ready;

    always_comb begin
        new_target = target_q;
        jump       = 1'b0;
        if (accept) begin
            case (cmd_op)
                2'd0: new_target = clamp({1'b0, cmd_data});
                2'd1: new_target = clamp({1'b0, target_q} + {1'b0, cmd_data});
                2'd2: new_target = (cmd_data > target_q) ? MIN_X[SPEED_W-1:0]
                                                         : clamp({1'b0, target_q - cmd_data});
                default: begin
                    new_target = clamp({1'b0, cmd_data});
                    jump       = 1'b1;
                end
            endcase
        end
    end

    // Steps aim at the freshly updated target so a command on the step edge takes effect at once.
    always_comb begin
        going_up = (new_target > speed_q);
        delta    = going_up ? (new_target - speed_q) : (speed_q - new_target);
        step     = (delta > STEP_V) ? STEP_V : delta;
        stepped  = going_up ? (speed_q + step) : (speed_q - step);
    end

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        target_d = target_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE: begin
                target_d = new_target;
                if (jump) begin
                    speed_d = new_target;
                    timer_d = '0;
                    state_d = ST_SYNC;
                end else if (new_target != speed_q) begin
                    timer_d = '0;
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                target_d = new_target;
                if (jump) begin
                    speed_d = new_target;
                    timer_d = '0;
                    state_d = ST_SYNC;
                end else if (new_target == speed_q) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    speed_d = stepped;
                    timer_d = '0;
                    state_d = ST_SYNC;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_SYNC: begin
                timer_d = '0;
                state_d = (speed_q != target_q) ? ST_RAMP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            speed_q    <= INIT_V;
            target_q   <= INIT_V;
            timer_q    <= '0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            target_q   <= target_d;
            timer_q    <= timer_d;
            rst_hold_q <= 1'b0;
        end
    end

endmodule
